// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet channel arbiters: the arbiter FSM
// state encoding and a constant-width helper.
package pkt_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_GRANT = 2'b01;
  localparam logic [1:0] ARB_BODY  = 2'b10;

  // Ceiling log2 for sizing index registers; returns at least 1.
  function automatic int clog2_int(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_rr_pick.sv
// Combinational round-robin picker: returns the first set candidate at or
// after rr_ptr, wrapping from N-1 back to 0.
module pkt_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_cand,
  output logic [IDX_W-1:0] winner
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  // Rotate the candidate vector so bit 0 is the requester at rr_ptr.
  assign dbl     = {cand, cand};
  assign shifted = dbl >> rr_ptr;
  assign rot     = shifted[N-1:0];

  // Take the lowest set bit of the rotated vector and map it back to an index.
  always_comb begin
    any_cand = 1'b0;
    winner   = '0;
    sum      = '0;
    for (int off = 0; off < N; off++) begin
      if (!any_cand && rot[off]) begin
        any_cand = 1'b1;
        sum      = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
        if (sum >= N_W) sum = sum - N_W;
        winner   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pkt_channel_arbiter.sv
// Packet-level round-robin arbiter sharing one head/data/tail channel
// between NUM_REQ requesters. A requester is granted on a head beat and
// keeps the channel until its tail beat is accepted.
//
// Handshake: a beat transfers on a cycle where valid and ready are both
// high; valid never depends on ready, and a source holds its beat stable
// while valid is high and the beat has not transferred.
//
// Optional macro PKT_ARB_TIMEOUT_EN: a stalled grant is force-released after
// TIMEOUT cycles without an accept and timeout_err pulses for that cycle.
module pkt_channel_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_head,
  input  logic [NUM_REQ-1:0]        req_tail,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic                      out_head,
  output logic                      out_tail,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      timeout_err,
  output arb_state_t                dbg_state,
  output logic [ID_W-1:0]           dbg_rr_ptr
);

  localparam int PTR_W = clog2_int(NUM_REQ);

  arb_state_t         state_q;
  logic [PTR_W-1:0]   grant_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   winner;
  logic [NUM_REQ-1:0] cand;
  logic               any_cand;
  logic               accept;
  logic               pkt_done;
  logic               stall_fire;
  logic               release_now;

  assign cand = req_valid & req_head;

  pkt_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .cand     (cand),
    .rr_ptr   (rr_ptr_q),
    .any_cand (any_cand),
    .winner   (winner)
  );

  assign busy = (state_q != ARB_IDLE);

  // Channel mux from the registered grant; everything is 0 while idle.
  always_comb begin
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy && grant_q == PTR_W'(i)) begin
        out_valid = req_valid[i];
        out_head  = req_head[i];
        out_tail  = req_tail[i];
        out_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && (grant_q == PTR_W'(i)) && out_valid && out_ready;
    end
  end

  assign accept = out_valid & out_ready;

  // A packet ends on an accepted tail in the body, or on a head+tail beat
  // while waiting for the head. A lone tail in ARB_GRANT does not end it.
  assign pkt_done = accept & out_tail &
                    (((state_q == ARB_GRANT) & out_head) | (state_q == ARB_BODY));

  assign release_now = busy & (pkt_done | stall_fire);

  assign next_ptr = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);

`ifdef PKT_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2_int(TIMEOUT);

  logic [CNT_W-1:0] stall_q;

  // An accept in the final stall cycle wins over the timeout.
  assign stall_fire = busy & ~accept & (stall_q == CNT_W'(TIMEOUT - 1));

  // Stall counter: cleared while idle (so fresh on entry to ARB_GRANT) and
  // on every accept, counts busy cycles without an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!busy || accept || stall_fire) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end
`else
  // No stall watchdog in this build; a negative TIMEOUT is meaningless, so
  // this term is constant 0.
  assign stall_fire = (TIMEOUT < 0);
`endif

  assign timeout_err = stall_fire;

  // Arbiter FSM: grant on a head candidate, lock until the packet ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_cand) begin
            grant_q <= winner;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept && out_head) state_q <= ARB_BODY;
        end
        ARB_BODY: ;
        default: state_q <= ARB_IDLE;
      endcase
      if (release_now) begin
        state_q  <= ARB_IDLE;
        grant_q  <= '0;
        rr_ptr_q <= next_ptr;
      end
    end
  end

  // Zero-extend the internal index registers onto the ID_W-wide outputs.
  always_comb begin
    grant_id               = '0;
    grant_id[PTR_W-1:0]    = grant_q;
    dbg_rr_ptr             = '0;
    dbg_rr_ptr[PTR_W-1:0]  = rr_ptr_q;
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_channel_arbiter.sv
// Self-checking bench for pkt_channel_arbiter: per-requester beat queues
// feed the DUT, a monitor pops expected beats as the channel accepts them.
module tb_pkt_channel_arbiter;
  import pkt_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;
  localparam int EXP_W   = ID_W + 2 + DATA_W;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_head;
  logic [NUM_REQ-1:0]        req_tail;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_head;
  logic                      out_tail;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      timeout_err;
  arb_state_t                dbg_state;
  logic [ID_W-1:0]           dbg_rr_ptr;

  logic [EXP_W-1:0]    exp_q[$];
  logic [DATA_W+1:0]   src_q[NUM_REQ][$];
  int                  n_checks = 0;
  int                  n_errors = 0;

  pkt_channel_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_head    (req_head),
    .req_tail    (req_tail),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_head    (out_head),
    .out_tail    (out_tail),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk_exp(input int id, input logic h, input logic t,
                                             input logic [DATA_W-1:0] d);
    return {ID_W'(id), h, t, d};
  endfunction

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  // Queue one beat at requester r and record it as expected on the channel.
  // Callers push beats in the order the arbiter is expected to grant them.
  task automatic push_beat(input int r, input logic h, input logic t, input logic [DATA_W-1:0] d);
    src_q[r].push_back({h, t, d});
    exp_q.push_back(mk_exp(r, h, t, d));
  endtask

  task automatic flush_all();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    flush_all();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && srcs_empty()) done = 1'b1;
    end
    if (!done) check_eq({tag, "_idle_timeout"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_grant(input string tag, input int id);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (busy) got = 1'b1;
    end
    if (got) check_eq(tag, 32'(grant_id), id);
    else     check_eq({tag, "_no_grant"}, 0, 1);
  endtask

  // Sources: beats present from just after a posedge; a beat is retired on
  // the edge after req_ready was seen high for it.
  initial begin : source_driver
    logic [NUM_REQ-1:0] acc;
    logic [DATA_W+1:0]  beat;
    req_valid = '0;
    req_head  = '0;
    req_tail  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          beat                        = src_q[i][0];
          req_valid[i]                = 1'b1;
          req_head[i]                 = beat[DATA_W+1];
          req_tail[i]                 = beat[DATA_W];
          req_data[i*DATA_W +: DATA_W] = beat[DATA_W-1:0];
        end else begin
          req_valid[i]                = 1'b0;
          req_head[i]                 = 1'b0;
          req_tail[i]                 = 1'b0;
          req_data[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", 32'({grant_id, out_head, out_tail, out_data}), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int r;
    int len;
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    check_eq("rst_busy",      32'(busy), 0);
    check_eq("rst_grant_id",  32'(grant_id), 0);
    check_eq("rst_state",     32'(dbg_state), 32'(ARB_IDLE));
    check_eq("rst_rr_ptr",    32'(dbg_rr_ptr), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_timeout",   32'(timeout_err), 0);

    // Single requester, three-beat packet.
    push_beat(0, 1'b1, 1'b0, 8'hA0);
    push_beat(0, 1'b0, 1'b0, 8'hA1);
    push_beat(0, 1'b0, 1'b1, 8'hA2);
    @(negedge clk);
    check_eq("s1_idle_arb_cycle", 32'(busy), 0);
    @(negedge clk);
    check_eq("s1_busy",  32'(busy), 1);
    check_eq("s1_grant", 32'(grant_id), 0);
    check_eq("s1_d0",    32'(out_data), 32'hA0);
    check_eq("s1_head",  32'(out_head), 1);
    @(negedge clk);
    check_eq("s1_d1",    32'(out_data), 32'hA1);
    @(negedge clk);
    check_eq("s1_d2",    32'(out_data), 32'hA2);
    check_eq("s1_tail",  32'(out_tail), 1);
    @(negedge clk);
    check_eq("s1_released", 32'(busy), 0);
    check_eq("s1_rr_ptr",   32'(dbg_rr_ptr), 1);
    wait_idle("s1");

    // Contention after reset: req1 then req3.
    do_reset();
    push_beat(1, 1'b1, 1'b0, 8'hB0);
    push_beat(1, 1'b0, 1'b1, 8'hB1);
    push_beat(3, 1'b1, 1'b0, 8'hC0);
    push_beat(3, 1'b0, 1'b0, 8'hC1);
    push_beat(3, 1'b0, 1'b1, 8'hC2);
    repeat (2) @(negedge clk);
    check_eq("s2_grant_first", 32'(grant_id), 1);
    check_eq("s2_rdy3_a",      32'(req_ready[3]), 0);
    @(negedge clk);
    check_eq("s2_rdy3_b",      32'(req_ready[3]), 0);
    check_eq("s2_tail1",       32'(out_tail), 1);
    @(negedge clk);
    check_eq("s2_gap_idle",    32'(busy), 0);
    @(negedge clk);
    check_eq("s2_grant_second", 32'(grant_id), 3);
    repeat (3) @(negedge clk);
    check_eq("s2_released",    32'(busy), 0);
    check_eq("s2_rr_wrap",     32'(dbg_rr_ptr), 0);
    wait_idle("s2");

    // Single-beat packet from req2.
    push_beat(2, 1'b1, 1'b1, 8'h5A);
    repeat (2) @(negedge clk);
    check_eq("s3_grant", 32'(grant_id), 2);
    check_eq("s3_ht",    32'({out_head, out_tail}), 32'b11);
    check_eq("s3_data",  32'(out_data), 32'h5A);
    @(negedge clk);
    check_eq("s3_state", 32'(dbg_state), 32'(ARB_IDLE));
    check_eq("s3_rr",    32'(dbg_rr_ptr), 3);
    wait_idle("s3");

    // Backpressure mid-body.
    push_beat(0, 1'b1, 1'b0, 8'hD0);
    push_beat(0, 1'b0, 1'b0, 8'hD1);
    push_beat(0, 1'b0, 1'b0, 8'hD2);
    push_beat(0, 1'b0, 1'b1, 8'hD3);
    repeat (2) @(negedge clk);
    check_eq("s4_grant", 32'(grant_id), 0);
    check_eq("s4_d0",    32'(out_data), 32'hD0);
    @(posedge clk);
    #2 out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("s4_hold_data",  32'(out_data), 32'hD1);
      check_eq("s4_hold_ready", 32'(req_ready), 0);
      check_eq("s4_hold_busy",  32'(busy), 1);
      check_eq("s4_hold_grant", 32'(grant_id), 0);
      check_eq("s4_no_timeout", 32'(timeout_err), 0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_idle("s4");
    check_eq("s4_rr", 32'(dbg_rr_ptr), 1);

    // Reset during req1's body.
    push_beat(1, 1'b1, 1'b0, 8'hE0);
    push_beat(1, 1'b0, 1'b0, 8'hE1);
    push_beat(1, 1'b0, 1'b0, 8'hE2);
    push_beat(1, 1'b0, 1'b1, 8'hE3);
    repeat (2) @(negedge clk);
    check_eq("s5_grant", 32'(grant_id), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    flush_all();
    @(negedge clk);
    check_eq("s5_busy",      32'(busy), 0);
    check_eq("s5_grant_id",  32'(grant_id), 0);
    check_eq("s5_req_ready", 32'(req_ready), 0);
    check_eq("s5_out_valid", 32'(out_valid), 0);
    check_eq("s5_rr",        32'(dbg_rr_ptr), 0);
    @(negedge clk);
    push_beat(1, 1'b1, 1'b0, 8'hF0);
    push_beat(1, 1'b0, 1'b1, 8'hF1);
    wait_grant("s5_regrant", 1);
    wait_idle("s5");

    // Random single-source packets under random backpressure.
    for (int p = 0; p < 8; p++) begin
      r   = int'($urandom_range(0, NUM_REQ - 1));
      len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        push_beat(r, b == 0, b == len - 1, 8'($urandom_range(0, 255)));
      end
      begin
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (!busy && exp_q.size() == 0 && srcs_empty()) done = 1'b1;
        end
        if (!done) check_eq("rand_idle_timeout", 32'(exp_q.size()), 0);
      end
      check_eq("rand_rr", 32'(dbg_rr_ptr), (r + 1) % NUM_REQ);
      @(posedge clk);
      #2 out_ready = 1'b1;
      @(negedge clk);
    end

`ifdef PKT_ARB_TIMEOUT_EN
    // req0 stalls after its head; req1 waits behind it.
    do_reset();
    push_beat(0, 1'b1, 1'b0, 8'h70);
    push_beat(1, 1'b1, 1'b1, 8'h71);
    repeat (2) @(negedge clk);
    check_eq("to_grant0", 32'(grant_id), 0);
    repeat (15) @(negedge clk);
    check_eq("to_before", 32'(timeout_err), 0);
    check_eq("to_busy_before", 32'(busy), 1);
    @(negedge clk);
    check_eq("to_pulse", 32'(timeout_err), 1);
    @(negedge clk);
    check_eq("to_released", 32'(busy), 0);
    check_eq("to_pulse_end", 32'(timeout_err), 0);
    check_eq("to_rr", 32'(dbg_rr_ptr), 1);
    @(negedge clk);
    check_eq("to_grant1", 32'(grant_id), 1);
    wait_idle("to");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
